// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation encodings and FSM state type.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_MULT = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DIV  = 2'd2;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle of the multi-cycle ALU; master drives requests, slave answers.
interface alu_mc_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_control;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             div_zero;

  modport master (
    output start, a, b, alu_control,
    input  busy, done, alu_result, hi, zero, div_zero
  );

  modport slave (
    input  start, a, b, alu_control,
    output busy, done, alu_result, hi, zero, div_zero
  );
endinterface

// File: rtl/alu_mc_muldiv.sv
// Iterative engine: unsigned shift-add multiply and restoring divide, one bit per cycle.
module alu_mc_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             dz
);

  localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);

  state_t           state;
  logic [SHW-1:0]   cnt;
  // lo: multiplier -> product low / dividend -> quotient; acc: product high / remainder.
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH-1:0] acc_n;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc, lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    acc_n     = mul_sum[WIDTH:1];
    lo_n      = {mul_sum[0], lo[WIDTH-1:1]};
    if (state == ST_DIV) begin
      acc_n = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_n  = {lo[WIDTH-2:0], div_ge};
    end
  end

  assign busy   = (state == ST_MUL) || (state == ST_DIV);
  assign last   = busy && (cnt == LAST_CNT);
  assign res_lo = lo_n;
  assign res_hi = acc_n;

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      lo    <= '0;
      acc   <= '0;
      opnd  <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_mul) begin
            state <= ST_MUL;
            lo    <= b;
            acc   <= '0;
            opnd  <= a;
            cnt   <= '0;
            dz    <= 1'b0;
          end else if (start_div) begin
            state <= ST_DIV;
            lo    <= a;
            acc   <= '0;
            opnd  <= b;
            cnt   <= '0;
            dz    <= (b == '0);
          end
        end
        ST_MUL, ST_DIV: begin
          lo  <= lo_n;
          acc <= acc_n;
          cnt <= cnt + 1'b1;
          if (last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: single-cycle logic/arith/shift ops plus iterative MULT/DIV engine.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus
);

  logic             md_busy;
  logic             md_last;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;
  logic             md_dz;

  logic             accept;
  logic             accept_single;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] comb_result;

  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] hi_q;
  logic             zero_q;
  logic             dz_q;
  logic             done_q;

  assign accept        = bus.start && !md_busy;
  assign accept_single = accept && !is_iterative(bus.alu_control);
  // Shift amount sits at b[SHW+5:6]; the shift-then-truncate form stays legal for narrow WIDTH.
  assign shamt         = SHW'(bus.b >> 6);

  alu_mc_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start_mul (accept && (bus.alu_control == OP_MULT)),
    .start_div (accept && (bus.alu_control == OP_DIV)),
    .a         (bus.a),
    .b         (bus.b),
    .busy      (md_busy),
    .last      (md_last),
    .res_lo    (md_lo),
    .res_hi    (md_hi),
    .dz        (md_dz)
  );

  always_comb begin
    comb_result = bus.a + bus.b;
    case (bus.alu_control)
      OP_AND:  comb_result = bus.a & bus.b;
      OP_OR:   comb_result = bus.a | bus.b;
      OP_SUB:  comb_result = bus.a - bus.b;
      OP_SLT:  comb_result = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU: comb_result = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      OP_SLL:  comb_result = bus.a << shamt;
      OP_SRL:  comb_result = bus.a >> shamt;
      OP_SRA:  comb_result = $unsigned($signed(bus.a) >>> shamt);
      OP_NOR:  comb_result = ~(bus.a | bus.b);
      OP_XOR:  comb_result = bus.a ^ bus.b;
      default: comb_result = bus.a + bus.b;
    endcase
  end

  // Single-cycle results and engine completion are exclusive: the engine only finishes while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_single) begin
        result_q <= comb_result;
        zero_q   <= (comb_result == '0);
        dz_q     <= 1'b0;
        done_q   <= 1'b1;
      end else if (md_last) begin
        result_q <= md_lo;
        hi_q     <= md_hi;
        zero_q   <= (md_lo == '0);
        dz_q     <= md_dz;
        done_q   <= 1'b1;
      end
    end
  end

  assign bus.busy       = md_busy;
  assign bus.done       = done_q;
  assign bus.alu_result = result_q;
  assign bus.hi         = hi_q;
  assign bus.zero       = zero_q;
  assign bus.div_zero   = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_alu_mc;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(32)) bus32 ();
  alu_mc_if #(.WIDTH(8))  bus8 ();

  alu_mc #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  alu_mc #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  typedef struct {
    logic [63:0] res;
    logic [63:0] hi;
    logic        zero;
    logic        dz;
    int          lat;
    int          issue;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  exp_t        q32[$];
  exp_t        q8[$];
  exp_t        e32;
  exp_t        e8;
  logic [63:0] hi32_m = '0;
  logic [63:0] hi8_m  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: results straight from the operation definitions on 64-bit integers.
  function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input int w, input logic [63:0] hi_prev);
    exp_t        e;
    logic [63:0] mask;
    logic [63:0] p;
    longint      sa;
    longint      sb;
    int          sh;
    mask = (64'd1 << w) - 64'd1;
    sh   = int'((b >> 6) & 64'(w - 1));
    sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    e.hi  = hi_prev;
    e.dz  = 1'b0;
    e.lat = 1;
    e.issue = 0;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0110: e.res = (a - b) & mask;
      4'b0111: e.res = (sa < sb) ? 64'd1 : 64'd0;
      4'b0011: e.res = (a < b) ? 64'd1 : 64'd0;
      4'b1000: e.res = (a << sh) & mask;
      4'b1001: e.res = a >> sh;
      4'b1010: e.res = a[w-1] ? ((a >> sh) | (mask & ~(mask >> sh))) : (a >> sh);
      4'b1100: e.res = ~(a | b) & mask;
      4'b0100: e.res = a ^ b;
      4'b0101: begin
        p     = a * b;
        e.res = p & mask;
        e.hi  = p >> w;
        e.lat = w + 1;
      end
      4'b1011: begin
        e.lat = w + 1;
        if (b == 0) begin
          e.res = mask;
          e.hi  = a;
          e.dz  = 1'b1;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
        end
      end
      default: e.res = (a + b) & mask;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  task automatic drive(input bit w8, input logic st, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (w8) begin
      bus8.start = st; bus8.alu_control = op; bus8.a = a[7:0]; bus8.b = b[7:0];
    end else begin
      bus32.start = st; bus32.alu_control = op; bus32.a = a[31:0]; bus32.b = b[31:0];
    end
  endtask

  // Issue one request, then spend exactly its latency scrambling inputs (ignored while busy);
  // returns at the negedge of the done cycle so the next request lands back-to-back.
  task automatic issue(input bit w8, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [63:0] mask;
    mask = w8 ? 64'hFF : 64'hFFFF_FFFF;
    e = model(op, a & mask, b & mask, w8 ? 8 : 32, w8 ? hi8_m : hi32_m);
    e.issue = cyc;
    if (op == 4'b0101 || op == 4'b1011) begin
      if (w8) hi8_m = e.hi; else hi32_m = e.hi;
    end
    if (w8) q8.push_back(e); else q32.push_back(e);
    drive(w8, 1'b1, op, a, b);
    @(negedge clk);
    for (int i = 1; i < e.lat; i++) begin
      drive(w8, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            {$urandom, $urandom}, {$urandom, $urandom});
      @(negedge clk);
    end
    drive(w8, 1'b0, 4'b0010, 64'd0, 64'd0);
  endtask

  task automatic random_op(input bit w8);
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    op = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 4'b0101 : 4'b1011)
                                     : 4'($urandom_range(0, 15));
    a  = {32'd0, $urandom};
    b  = ($urandom_range(0, 4) == 0) ? 64'd0 : {32'd0, $urandom};
    issue(w8, op, a, b);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy32"},   {63'd0, bus32.busy},     64'd0);
    check({tag, "_done32"},   {63'd0, bus32.done},     64'd0);
    check({tag, "_result32"}, {32'd0, bus32.alu_result}, 64'd0);
    check({tag, "_hi32"},     {32'd0, bus32.hi},       64'd0);
    check({tag, "_zero32"},   {63'd0, bus32.zero},     64'd1);
    check({tag, "_dz32"},     {63'd0, bus32.div_zero}, 64'd0);
    check({tag, "_busy8"},    {63'd0, bus8.busy},      64'd0);
    check({tag, "_result8"},  {56'd0, bus8.alu_result}, 64'd0);
    check({tag, "_zero8"},    {63'd0, bus8.zero},      64'd1);
  endtask

  always @(negedge clk) begin
    if (!reset && bus32.done) begin
      check("busy_done_excl32", {63'd0, bus32.busy}, 64'd0);
      if (q32.size() == 0) begin
        check("done_expected32", 64'd0, 64'd1);
      end else begin
        e32 = q32.pop_front();
        check("result32",  {32'd0, bus32.alu_result}, e32.res);
        check("hi32",      {32'd0, bus32.hi},         e32.hi);
        check("zero32",    {63'd0, bus32.zero},       {63'd0, e32.zero});
        check("div_zero32", {63'd0, bus32.div_zero},  {63'd0, e32.dz});
        check("latency32", 64'(cyc - e32.issue),      64'(e32.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus8.done) begin
      check("busy_done_excl8", {63'd0, bus8.busy}, 64'd0);
      if (q8.size() == 0) begin
        check("done_expected8", 64'd0, 64'd1);
      end else begin
        e8 = q8.pop_front();
        check("result8",  {56'd0, bus8.alu_result}, e8.res);
        check("hi8",      {56'd0, bus8.hi},         e8.hi);
        check("zero8",    {63'd0, bus8.zero},       {63'd0, e8.zero});
        check("div_zero8", {63'd0, bus8.div_zero},  {63'd0, e8.dz});
        check("latency8", 64'(cyc - e8.issue),      64'(e8.lat));
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'b0010, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 4'b0010, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);

    // Directed 32-bit cases, issued back-to-back.
    issue(1'b0, 4'b0110, 64'd5, 64'd5);
    issue(1'b0, 4'b0111, 64'hFFFF_FFFF, 64'd1);
    issue(1'b0, 4'b0011, 64'hFFFF_FFFF, 64'd1);
    issue(1'b0, 4'b1010, 64'h8000_0000, 64'd4 << 6);
    issue(1'b0, 4'b0101, 64'hFFFF_FFFF, 64'd2);
    issue(1'b0, 4'b0110, 64'd5, 64'd5);
    issue(1'b0, 4'b1011, 64'd100, 64'd7);
    issue(1'b0, 4'b1011, 64'd9, 64'd0);
    issue(1'b0, 4'b1010, 64'h8000_0000, 64'd0);
    issue(1'b0, 4'b1111, 64'hFFFF_FFFF, 64'd1);

    // Abort a DIV around iteration 10: asynchronous reset, no done afterwards.
    drive(1'b0, 1'b1, 4'b1011, 64'd1000, 64'd3);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'b0010, 64'd0, 64'd0);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals("abort");
    hi32_m = '0;
    hi8_m  = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    issue(1'b0, 4'b0101, 64'd3, 64'd7);

    for (int i = 0; i < 40; i++) random_op(1'b0);

    // 8-bit instance.
    issue(1'b1, 4'b0101, 64'hFF, 64'hFF);
    issue(1'b1, 4'b1011, 64'hC8, 64'd0);
    issue(1'b1, 4'b0000, 64'hF0, 64'h3C);
    for (int i = 0; i < 20; i++) random_op(1'b1);

    repeat (40) @(negedge clk);
    check("drain32", 64'(q32.size()), 64'd0);
    check("drain8",  64'(q8.size()),  64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
